// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst_n.
// Optional lock-loss counter enabled by defining PLL_SEQ_LOSS_COUNT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// PLL_RST   | pll_rst held high for PLL_RST_CYCLES cycles
// WAIT_LOCK | PLL running, waiting for locked_s; retry on LOCK_TIMEOUT
// STABLE    | locked_s must stay high for STABLE_CYCLES cycles
// RUN       | system reset released; a lock loss restarts the sequence
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STABLE_CYCLES  = 256
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sw_restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic [1:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 16) ? $clog2(MAX_CYC) : 16;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_m, locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_restart) begin
            state_d = PLL_RST;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s)                                state_d = STABLE;
                    else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))  state_d = PLL_RST;
                end
                STABLE: begin
                    if (!locked_s)                               state_d = WAIT_LOCK;
                    else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) state_d = PLL_RST;
                end
                default: state_d = PLL_RST;
            endcase
        end
        // Counter restarts on every state entry, including a restart into PLL_RST itself.
        cnt_d = (sw_restart || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
    end

    // Outputs decoded from the next state so they change on the same edge as state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst   <= (state_d == PLL_RST);
            sys_rst_n <= (state_d == RUN);
        end
    end

    assign state = state_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic       loss_event;
    logic [7:0] loss_q;

    assign loss_event = (state_q == RUN) && !locked_s && !sw_restart;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= 8'd0;
        end else if (loss_event && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule
